// File: rtl/mult_pkg.sv
// Shared defaults and helpers for the round-robin multiplier arbiter.
package mult_pkg;

  localparam int unsigned DefNReq = 4;
  localparam int unsigned DefW    = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// Shared W x W multiplier feeding the result (S2) register; holds when en is low.
module mult_pipe_stage import mult_pkg::*; #(
  parameter int unsigned W   = DefW,
  parameter int unsigned IdW = id_width(DefNReq)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  input  logic [IdW-1:0] in_id,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  output logic [IdW-1:0] out_id,
  output logic [W-1:0]   out_data
);

  logic [W-1:0] product;

  // Product is evaluated in a W-bit context, so it is already truncated mod 2^W.
  assign product = in_a * in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_id   <= in_id;
        out_data <= product;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one two-stage multiplier pipeline among N_REQ requesters.
module mult_arbiter import mult_pkg::*; #(
  parameter int unsigned N_REQ = DefNReq,
  parameter int unsigned W     = DefW,
  localparam int unsigned IdW  = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [IdW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_data,
  input  logic               rsp_ready,
  output logic               busy
);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic           s1_valid_q;
  logic [IdW-1:0] s1_id_q;
  logic [W-1:0]   s1_a_q, s1_b_q;

  logic           advance;
  logic           grant_found;
  logic           do_grant;
  logic [IdW-1:0] grant_id;
  int unsigned    cand;

  assign advance = !rsp_valid | rsp_ready;

  // Search upward from ptr with wrap-around; first requesting index wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = IdW'(cand);
      end
    end
  end

  // rst_n gates the grant so req_ready is zero throughout reset.
  assign do_grant  = grant_found & advance & rst_n;
  assign req_ready = do_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (do_grant) begin
      ptr_d = (grant_id == IdW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (advance) begin
        s1_valid_q <= do_grant;
        if (do_grant) begin
          s1_id_q <= grant_id;
          s1_a_q  <= req_a[grant_id*W +: W];
          s1_b_q  <= req_b[grant_id*W +: W];
        end
      end
    end
  end

  mult_pipe_stage #(
    .W   (W),
    .IdW (IdW)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (advance),
    .in_valid  (s1_valid_q),
    .in_id     (s1_id_q),
    .in_a      (s1_a_q),
    .in_b      (s1_b_q),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_data  (rsp_data)
  );

  assign busy = s1_valid_q | rsp_valid;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: per-cycle comparison against a behavioural model plus literals.
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready = 1'b1;
  logic           busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_arbiter #(
    .N_REQ (N),
    .W     (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  // Behavioural model: a priority pointer and two in-flight result slots (0 = newest).
  int m_ptr = 0;
  bit m_v[2];
  int m_id[2];
  int m_d[2];
  int m_g;

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = pick();
    if (rst_n && (!m_v[1] || rsp_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0;
      m_v[0] = 1'b0;
      m_v[1] = 1'b0;
    end else if (!m_v[1] || rsp_ready) begin
      m_g = pick();
      m_v[1] = m_v[0];
      m_id[1] = m_id[0];
      m_d[1] = m_d[0];
      if (m_g >= 0) begin
        m_v[0] = 1'b1;
        m_id[0] = m_g;
        m_d[0] = (int'(req_a[m_g*W +: W]) * int'(req_b[m_g*W +: W])) % 256;
        m_ptr = (m_g + 1) % N;
      end else begin
        m_v[0] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("model req_ready", req_ready, exp_ready());
    check("model rsp_valid", rsp_valid, m_v[1]);
    check("model busy", busy, m_v[0] | m_v[1]);
    if (m_v[1]) begin
      check("model rsp_id", rsp_id, m_id[1]);
      check("model rsp_data", rsp_data, m_d[1]);
    end else if (!rst_n) begin
      check("model rst rsp_id", rsp_id, 0);
      check("model rst rsp_data", rsp_data, 0);
    end
  end

  logic [3:0] e_rdy;

  initial begin
    // Reset with requests pending: no grant may leak out.
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    check("rst req_ready", req_ready, 0);
    check("rst busy", busy, 0);
    check("rst rsp_valid", rsp_valid, 0);
    step();
    req_valid = '0;
    rst_n = 1'b1;
    step();

    // Single op 3*5 on requester 2.
    set_op(2, 3, 5);
    req_valid = 4'b0100;
    @(negedge clk);
    check("single grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    check("single early rsp_valid", rsp_valid, 0);
    check("single busy", busy, 1);
    step();
    @(negedge clk);
    check("single rsp_valid", rsp_valid, 1);
    check("single rsp_id", rsp_id, 2);
    check("single rsp_data", rsp_data, 15);
    step();
    step();

    // Truncation, back-to-back on requester 0.
    set_op(0, 20, 20);
    req_valid = 4'b0001;
    step();
    set_op(0, 255, 255);
    step();
    req_valid = '0;
    @(negedge clk);
    check("trunc 20*20", rsp_data, 8'h90);
    step();
    @(negedge clk);
    check("trunc 255*255", rsp_data, 1);
    step();
    step();

    // Fairness: all requesters valid from reset.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
    req_valid = 4'hF;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      e_rdy = 4'b0001 << (c % 4);
      check("fair grant", req_ready, e_rdy);
      if (c >= 2) begin
        check("fair rsp_id", rsp_id, (c - 2) % 4);
        check("fair rsp_data", rsp_data, ((c - 2) % 4 + 1) * 10);
      end
      step();
    end
    req_valid = '0;
    repeat (3) step();

    // Backpressure: two accepts, then five stalled cycles.
    set_op(0, 7, 3);
    req_valid = 4'b0001;
    step();
    set_op(0, 9, 9);
    step();
    rsp_ready = 1'b0;
    set_op(1, 4, 4);
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall req_ready", req_ready, 0);
      check("stall rsp_valid", rsp_valid, 1);
      check("stall rsp_id", rsp_id, 0);
      check("stall rsp_data", rsp_data, 21);
      step();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("release first", rsp_data, 21);
    step();
    @(negedge clk);
    check("release second valid", rsp_valid, 1);
    check("release second", rsp_data, 81);
    step();
    @(negedge clk);
    check("release no dup", rsp_valid, 0);
    step();

    // Reset mid-operation.
    set_op(2, 2, 2);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("async busy", busy, 0);
    check("async rsp_valid", rsp_valid, 0);
    check("async rsp_data", rsp_data, 0);
    check("async rsp_id", rsp_id, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post-reset no phantom", rsp_valid, 0);
    req_valid = 4'b1010;
    @(negedge clk);
    check("post-reset first grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    repeat (3) step();

    // Sparse requests from requester 1 every third cycle.
    for (int r = 0; r < 4; r++) begin
      set_op(1, r + 3, r + 5);
      req_valid = 4'b0010;
      @(negedge clk);
      check("sparse grant", req_ready, 4'b0010);
      step();
      req_valid = '0;
      @(negedge clk);
      check("sparse ptr", dut.ptr_q, 2);
      step();
      step();
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
